// File: rtl/prog_loader.sv
// prog_loader: validates instruction field bundles, packs them into
// 32-bit words and writes them to program RAM, then appends HLT.
module prog_loader #(
  parameter int RAM_SIZE = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        finish,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  in_cond,
  input  logic [2:0]  in_super,
  input  logic [3:0]  in_sub,
  input  logic [3:0]  in_funct,
  input  logic [7:0]  in_arg1,
  input  logic [7:0]  in_arg2,
  output logic        mem_we,
  output logic [7:0]  mem_addr,
  output logic [31:0] mem_wdata,
  output logic [8:0]  word_count,
  output logic        busy,
  output logic        done,
  output logic        full,
  output logic        err,
  output logic [1:0]  err_code
);

  localparam logic [8:0]  LIMIT = 9'(RAM_SIZE);
  localparam logic [31:0] HLT   = 32'h0001_0000;

  // DRAIN lets a bundle accepted with finish reach RAM before HLT
  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_DRAIN,
    S_TERM,
    S_DONE
  } state_e;

  state_e      state_q;
  logic [8:0]  wc_q;
  logic        err_q;
  logic [1:0]  code_q;
  logic        we_q;
  logic [7:0]  addr_q;
  logic [31:0] data_q;

  logic        full_w;
  logic        accept;
  logic        reg_op;
  logic        reg_bad;
  logic [1:0]  cause;
  logic [31:0] word;

  assign full_w = (wc_q == LIMIT);
  assign accept = in_valid && in_ready;
  assign word   = {in_cond, in_super, in_sub,
                   in_funct, in_arg1, in_arg2};

  assign reg_op  = (in_funct >= 4'd3) && (in_funct <= 4'd5);
  assign reg_bad = (reg_op && (in_arg1 > 8'd3)) ||
                   ((in_funct == 4'd5) && (in_arg2 > 8'd3));

  // classify the bundle; the first failing check is the cause
  always_comb begin
    cause = 2'd0;
    if (in_cond > 5'h12) begin
      cause = 2'd1;
    end else if ((in_super == 3'd0) && in_funct[3]) begin
      cause = 2'd2;
    end else if ((in_super == 3'd0) && reg_bad) begin
      cause = 2'd3;
    end
  end

  // loader FSM with registered RAM write port and counters
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      wc_q    <= 9'd0;
      err_q   <= 1'b0;
      code_q  <= 2'd0;
      we_q    <= 1'b0;
      addr_q  <= 8'd0;
      data_q  <= 32'd0;
    end else if (start) begin
      state_q <= S_LOAD;
      wc_q    <= 9'd0;
      err_q   <= 1'b0;
      code_q  <= 2'd0;
      we_q    <= 1'b0;
    end else begin
      we_q <= 1'b0;
      case (state_q)
        S_LOAD: begin
          if (accept) begin
            if (cause == 2'd0) begin
              we_q   <= 1'b1;
              addr_q <= wc_q[7:0];
              data_q <= word;
              wc_q   <= wc_q + 9'd1;
            end else begin
              err_q <= 1'b1;
              if (!err_q) code_q <= cause;
            end
          end
          if (finish) state_q <= S_DRAIN;
        end
        S_DRAIN: begin
          if (wc_q < LIMIT) begin
            we_q   <= 1'b1;
            addr_q <= wc_q[7:0];
            data_q <= HLT;
            wc_q   <= wc_q + 9'd1;
          end
          state_q <= S_TERM;
        end
        S_TERM:  state_q <= S_DONE;
        default: state_q <= state_q;
      endcase
    end
  end

  assign in_ready   = (state_q == S_LOAD) && !full_w;
  assign full       = full_w;
  assign busy       = (state_q == S_LOAD) ||
                      (state_q == S_DRAIN) ||
                      (state_q == S_TERM);
  assign done       = (state_q == S_DONE);
  assign mem_we     = we_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = data_q;
  assign word_count = wc_q;
  assign err        = err_q;
  assign err_code   = code_q;

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: directed stimulus, event-schedule reference model
// checked every cycle, plus literal expectations from hand-encoded words.
module tb_prog_loader;

  localparam int RS = 4;
  localparam logic [31:0] HLT_W = 32'h0001_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        finish = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  in_cond = '0;
  logic [2:0]  in_super = '0;
  logic [3:0]  in_sub = '0;
  logic [3:0]  in_funct = '0;
  logic [7:0]  in_arg1 = '0;
  logic [7:0]  in_arg2 = '0;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [8:0]  word_count;
  logic        busy;
  logic        done;
  logic        full;
  logic        err;
  logic [1:0]  err_code;

  always #5 clk = ~clk;

  prog_loader #(.RAM_SIZE(RS)) dut (
    .clk(clk), .reset(reset), .start(start), .finish(finish),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_cond(in_cond), .in_super(in_super), .in_sub(in_sub),
    .in_funct(in_funct), .in_arg1(in_arg1), .in_arg2(in_arg2),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .word_count(word_count), .busy(busy), .done(done),
    .full(full), .err(err), .err_code(err_code)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // reference rules: cause of rejection, 0 when legal
  function automatic int cause_of(input logic [4:0] c, input logic [2:0] s,
                                  input logic [3:0] f, input logic [7:0] a1,
                                  input logic [7:0] a2);
    int fi;
    fi = int'(f);
    if (int'(c) >= 19) return 1;
    if (s != 3'd0) return 0;
    if (fi >= 8) return 2;
    if (fi == 3 || fi == 4) return (int'(a1) <= 3) ? 0 : 3;
    if (fi == 5) return (int'(a1) <= 3 && int'(a2) <= 3) ? 0 : 3;
    return 0;
  endfunction

  function automatic logic [31:0] enc(input logic [4:0] c, input logic [2:0] s,
                                      input logic [3:0] sb, input logic [3:0] f,
                                      input logic [7:0] a1, input logic [7:0] a2);
    logic [31:0] w;
    w = 32'(c) * 32'h0800_0000 + 32'(s) * 32'h0100_0000
      + 32'(sb) * 32'h0010_0000 + 32'(f) * 32'h0001_0000
      + 32'(a1) * 32'd256 + 32'(a2);
    return w;
  endfunction

  // model state: schedule of future events by cycle index
  int          cyc = 0;
  bit          m_load = 0, m_fin = 0, m_done = 0, m_err = 0, m_we = 0;
  int          m_wc = 0, m_code = 0, m_addr = 0;
  logic [31:0] m_data = '0;
  int          hlt_due = -1, done_due = -1;
  logic [31:0] ram [RS];

  task automatic model_step();
    bit rdy;
    int c;
    rdy = m_load && (m_wc < RS);
    cyc++;
    if (reset) begin
      m_load = 0; m_fin = 0; m_done = 0; m_err = 0; m_code = 0;
      m_wc = 0; m_we = 0; m_addr = 0; m_data = '0;
      hlt_due = -1; done_due = -1;
    end else if (start) begin
      m_load = 1; m_fin = 0; m_done = 0; m_err = 0; m_code = 0;
      m_wc = 0; m_we = 0; hlt_due = -1; done_due = -1;
    end else begin
      m_we = 0;
      if (rdy && in_valid) begin
        c = cause_of(in_cond, in_super, in_funct, in_arg1, in_arg2);
        if (c == 0) begin
          m_we = 1; m_addr = m_wc;
          m_data = enc(in_cond, in_super, in_sub, in_funct, in_arg1, in_arg2);
          m_wc++;
        end else begin
          if (!m_err) m_code = c;
          m_err = 1;
        end
      end
      if (hlt_due == cyc && m_wc < RS) begin
        m_we = 1; m_addr = m_wc; m_data = HLT_W; m_wc++;
      end
      if (done_due == cyc) begin
        m_done = 1; m_fin = 0;
      end
      if (finish && m_load) begin
        m_load = 0; m_fin = 1;
        hlt_due = cyc + 1; done_due = cyc + 2;
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  // compare process: every cycle, away from the active edge
  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      chk("mem_we", 32'(mem_we), 32'(m_we));
      if (m_we) begin
        chk("mem_addr", 32'(mem_addr), 32'(m_addr));
        chk("mem_wdata", mem_wdata, m_data);
      end
      if (mem_we === 1'b1 && int'(mem_addr) < RS) ram[mem_addr] = mem_wdata;
      chk("word_count", 32'(word_count), 32'(m_wc));
      chk("in_ready", 32'(in_ready), 32'(m_load && (m_wc < RS)));
      chk("busy", 32'(busy), 32'(m_load || m_fin));
      chk("done", 32'(done), 32'(m_done));
      chk("full", 32'(full), 32'(m_wc == RS));
      chk("err", 32'(err), 32'(m_err));
      chk("err_code", 32'(err_code), 32'(m_code));
    end
  end

  task automatic drv(input bit v, input bit st, input bit fin,
                     input logic [4:0] c, input logic [2:0] s,
                     input logic [3:0] sb, input logic [3:0] f,
                     input logic [7:0] a1, input logic [7:0] a2);
    in_valid = v; start = st; finish = fin;
    in_cond = c; in_super = s; in_sub = sb;
    in_funct = f; in_arg1 = a1; in_arg2 = a2;
    @(negedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_start();
    drv(0, 1, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic jmp10();
    drv(1, 0, 0, 5'h00, 3'd0, 4'd0, 4'd2, 8'h10, 8'h00);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    #1;
    chk("rst mem_we", 32'(mem_we), 32'd0);
    chk("rst mem_addr", 32'(mem_addr), 32'd0);
    chk("rst mem_wdata", mem_wdata, 32'd0);
    chk("rst word_count", 32'(word_count), 32'd0);
    chk("rst busy_done", 32'({busy, done, in_ready}), 32'd0);
    chk("rst err", 32'({err, err_code}), 32'd0);
    reset = 1'b0;

    // MOV AL,5 then finish
    do_start();
    drv(1, 0, 0, 5'h00, 3'd0, 4'd0, 4'd4, 8'h00, 8'h05);
    drv(0, 0, 1, 0, 0, 0, 0, 0, 0);
    idle(3);
    chk("mov addr0", ram[0], 32'h0004_0005);
    chk("mov addr1 hlt", ram[1], 32'h0001_0000);
    chk("mov word_count", 32'(word_count), 32'd2);
    chk("mov done", 32'(done), 32'd1);

    // bad cond, then legal cond 0x12 lands at addr0
    do_start();
    drv(1, 0, 0, 5'h13, 3'd0, 4'd0, 4'd0, 8'h00, 8'h00);
    chk("badcond we", 32'(mem_we), 32'd0);
    chk("badcond err", 32'({err, err_code}), 32'b101);
    drv(1, 0, 0, 5'h12, 3'd0, 4'd0, 4'd1, 8'h00, 8'h00);
    idle(1);
    chk("cond12 addr0", ram[0], 32'h9001_0000);
    chk("cond12 code", 32'(err_code), 32'd1);

    // bad reg, then bad funct keeps first cause, then boundary legal
    do_start();
    drv(1, 0, 0, 5'h00, 3'd0, 4'd0, 4'd5, 8'h01, 8'h04);
    chk("badreg code", 32'(err_code), 32'd3);
    drv(1, 0, 0, 5'h00, 3'd0, 4'd0, 4'd8, 8'h00, 8'h00);
    chk("badfunct sticky", 32'(err_code), 32'd3);
    drv(1, 0, 0, 5'h00, 3'd0, 4'd0, 4'd5, 8'h03, 8'h03);
    drv(1, 0, 0, 5'h00, 3'd1, 4'd0, 4'd8, 8'hFF, 8'hFF);
    idle(1);
    chk("reg3 addr0", ram[0], 32'h0005_0303);
    chk("super1 addr1", ram[1], 32'h0108_FFFF);
    chk("err wc", 32'(word_count), 32'd2);

    // fill RAM, finish skips HLT
    do_start();
    repeat (4) jmp10();
    chk("jmp addr3", ram[3], 32'h0002_1000);
    jmp10();
    chk("full flag", 32'(full), 32'd1);
    chk("full ready", 32'(in_ready), 32'd0);
    drv(0, 0, 1, 0, 0, 0, 0, 0, 0);
    idle(3);
    chk("full done", 32'(done), 32'd1);
    chk("full wc", 32'(word_count), 32'd4);
    chk("full kept", 32'(full), 32'd1);

    // bundle with finish in same cycle
    do_start();
    drv(1, 0, 1, 5'h01, 3'd2, 4'd3, 4'd6, 8'hAB, 8'hCD);
    chk("n1 we", 32'(mem_we), 32'd1);
    chk("n1 word", mem_wdata, 32'h0A36_ABCD);
    chk("n1 done", 32'(done), 32'd0);
    idle(1);
    chk("n2 we", 32'(mem_we), 32'd1);
    chk("n2 hlt", mem_wdata, 32'h0001_0000);
    chk("n2 addr", 32'(mem_addr), 32'd1);
    idle(1);
    chk("n3 done", 32'(done), 32'd1);
    chk("n3 we", 32'(mem_we), 32'd0);

    // reset mid-load after 3 words
    do_start();
    repeat (3) jmp10();
    reset = 1'b1;
    idle(1);
    chk("mid rst we", 32'(mem_we), 32'd0);
    chk("mid rst addr", 32'(mem_addr), 32'd0);
    chk("mid rst data", mem_wdata, 32'd0);
    chk("mid rst wc", 32'(word_count), 32'd0);
    chk("mid rst flags", 32'({busy, done, full, in_ready, err}), 32'd0);
    reset = 1'b0;
    do_start();
    drv(1, 0, 0, 5'h00, 3'd0, 4'd0, 4'd4, 8'h00, 8'h05);
    chk("reload addr", 32'(mem_addr), 32'd0);
    idle(1);
    chk("reload addr0", ram[0], 32'h0004_0005);
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
